// File: rtl/shift_reg_sre_if.sv
// Bus bundle for shift_reg_sre: shift/tap inputs from the master, tap data and fill status back.
interface shift_reg_sre_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             CE;
    logic [WIDTH-1:0] D;
    logic [AW-1:0]    A;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_LAST;
    logic             VALID;
    logic [AW:0]      FILL;

    modport master (output CE, D, A, input Q, Q_LAST, VALID, FILL);
    modport slave  (input CE, D, A, output Q, Q_LAST, VALID, FILL);
endinterface

// File: rtl/shift_reg_sre.sv
// Addressable WIDTH x DEPTH shift register with sync reset, clock enable, fill tracking
// and an optionally registered read tap.
module shift_reg_sre #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 16,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SRVAL = {WIDTH{1'b0}},
    parameter bit               QREG  = 1'b1
) (
    input  logic           C,
    input  logic           R,
    shift_reg_sre_if.slave bus
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH - 1);
    localparam logic [AW:0]     ONE_W   = (AW+1)'(1);

    logic [WIDTH-1:0] stage_r [DEPTH] = '{default: INIT};
    logic [AW:0]      fill_r          = {(AW+1){1'b0}};
    logic [AW-1:0]    a_eff_s;
    logic [WIDTH-1:0] tap_s;
    logic             vld_s;

    // Addresses past the last stage only exist for non-power-of-2 depths; they read the oldest stage.
    if ((1 << AW) == DEPTH) begin : g_pow2
        assign a_eff_s = bus.A;
    end else begin : g_clamp
        // Clamp the read address onto the last stage.
        always_comb begin
            if ({1'b0, bus.A} >= DEPTH_W) begin
                a_eff_s = LAST_A;
            end else begin
                a_eff_s = bus.A;
            end
        end
    end

    // Tap data and its validity from the pre-edge array and fill count.
    always_comb begin
        tap_s = stage_r[a_eff_s];
        vld_s = (fill_r > {1'b0, a_eff_s});
    end

    // Shift chain and saturating fill counter; reset wins over clock enable.
    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= SRVAL;
            end
            fill_r <= {(AW+1){1'b0}};
        end else if (bus.CE) begin
            stage_r[0] <= bus.D;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            if (fill_r != DEPTH_W) begin
                fill_r <= fill_r + ONE_W;
            end
        end
    end

    if (QREG) begin : g_qreg
        logic [WIDTH-1:0] q_r     = INIT;
        logic             valid_r = 1'b0;

        // Output register samples the tap every cycle, independent of CE.
        always_ff @(posedge C) begin
            if (R) begin
                q_r     <= SRVAL;
                valid_r <= 1'b0;
            end else begin
                q_r     <= tap_s;
                valid_r <= vld_s;
            end
        end

        assign bus.Q     = q_r;
        assign bus.VALID = valid_r;
    end else begin : g_qcomb
        assign bus.Q     = tap_s;
        assign bus.VALID = vld_s;
    end

    assign bus.Q_LAST = stage_r[DEPTH-1];
    assign bus.FILL   = fill_r;
endmodule

// File: doc/shift_reg_sre.md
# shift_reg_sre

Parametrised, addressable multi-bit shift register with synchronous active-high reset, clock enable and per-tap fill tracking. Generalises the single-bit clock-enabled flip-flop primitive to WIDTH bits × DEPTH stages with a dynamic read tap and optional output register. It belongs to the unisim-style primitive library used by the equivalence and model-checking flows, and is the reference model for SRL-style delay lines.

## Interface
- WIDTH, 8, data width in bits (1..64)
- DEPTH, 16, number of stages (2..256); AW = clog2(DEPTH)
- INIT, {WIDTH{1'b0}}, power-up value of every stage and of Q
- SRVAL, {WIDTH{1'b0}}, value loaded into every stage and Q on R
- QREG, 1, 1 = tap output registered, 0 = tap output combinational

- C  in  1  clock; all state changes on posedge C
- R  in  1  reset; synchronous, active-high; priority over CE
- CE  in  1  clock enable for shift and fill counter
- D  in  WIDTH  data shifted into stage 0
- A  in  AW  read tap address; 0 = newest stage
- Q  out  WIDTH  tap data, stage[A]
- Q_LAST  out  WIDTH  stage[DEPTH-1], always combinational from the stage array
- VALID  out  1  tap A holds data shifted in since the last reset
- FILL  out  AW+1  count of stages holding post-reset data, saturating at DEPTH

## Operation
- Power-up, before any R: stages = INIT, Q = INIT, FILL = 0, VALID = 0.
- R = 1 at posedge C: all stages <= SRVAL, FILL <= 0, Q <= SRVAL (QREG=1), VALID <= 0. CE and D are ignored.
- R = 0, CE = 1: stage[0] <= D; stage[i] <= stage[i-1] for i = 1..DEPTH-1; FILL <= min(FILL+1, DEPTH).
- R = 0, CE = 0: stages and FILL hold.
- Tap select: tap = stage[A] when A < DEPTH; when A >= DEPTH (non-power-of-2 DEPTH), tap = stage[DEPTH-1].
- Valid select: vld = (FILL > A_eff), where A_eff is the clamped address.
- QREG = 1: at every posedge with R = 0, Q <= tap and VALID <= vld, both computed from pre-edge stages and FILL. Not gated by CE.
- QREG = 0: Q = tap, VALID = vld, combinational from current state and A.
- FILL arithmetic is unsigned AW+1 bits. It saturates at DEPTH and never wraps.
- No read/write hazard: the shift and the tap sample use the same pre-edge array.

## Timing
- Input-to-stage latency: D appears in stage[0] one posedge after CE = 1.
- Sample written at CE-edge k reaches stage[j] after j further CE-qualified edges.
- QREG = 0: Q reflects new stages and A in the same cycle, with zero-cycle address latency.
- QREG = 1: one extra cycle. A change is visible on Q after the next posedge.
- Reset takes effect at the same edge it is sampled. Q/VALID (QREG=1) and Q_LAST show SRVAL/0 in the following cycle.
- Reset mid-fill: FILL returns to 0 regardless of its prior value. Data shifted on the R edge is lost.
- Simultaneous R and CE: reset wins, and FILL = 0 after the edge, not 1.
- FILL = DEPTH with CE = 1: FILL stays DEPTH and stage[DEPTH-1] is discarded.

## Test plan
- WIDTH=8, DEPTH=4, QREG=0: R for 1 cycle, then CE=1 with D=0x11,0x22,0x33,0x44 -> with A=0 Q=0x44, A=3 Q=0x11, Q_LAST=0x11, FILL=4, VALID=1 for all A.
- Same config, after R, two CE pulses D=0xA1,0xA2 -> FILL=2; A=1 Q=0xA1 VALID=1; A=2 Q=SRVAL(0x00) VALID=0.
- CE toggling 1,0,0,1 with D=0x05,0xFF,0xFF,0x06 -> only 0x05 then 0x06 enter; stage[0]=0x06, stage[1]=0x05, FILL=2.
- QREG=1, full array 0x11..0x44, A stepped 0->3 in consecutive cycles -> Q one cycle behind A: 0x44,0x33,0x22,0x11.
- R=1 and CE=1 together with D=0x7E on a full array -> next cycle all taps 0x00, FILL=0, VALID=0, Q_LAST=0x00.
- DEPTH=5 (AW=3), A=7 after 5 shifts of 0x01..0x05 -> Q=0x01 (clamped to stage[4]), VALID=1. Six more shifts -> FILL remains 5.
